// File: rtl/gpio_irq_ctrl_if.sv
// rtl/gpio_irq_ctrl_if.sv - scarv_ccx_memif word-register bus interface
//
// Purpose: request/response memory interface between the CPU complex and a
//          peripheral register block.
// Signals: req/wen/strb/addr/wdata from the requester; gnt/error/rdata
//          returned by the responder.
// Modports: REQ (requester side), RSP (responder side).
interface scarv_ccx_memif;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport REQ (output req, wen, strb, addr, wdata, input gnt, error, rdata);
  modport RSP (input req, wen, strb, addr, wdata, output gnt, error, rdata);
endinterface

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO pin synchroniser, debouncer and edge interrupt controller
//
// Purpose: per pin, synchronise the raw level, debounce it, detect rising and
//          falling edges on the debounced level, latch enabled edges into a
//          write-1-to-clear PENDING register and drive a registered irq.
// Ports:
//   g_clk      in   clock, all logic on its rising edge
//   g_resetn   in   synchronous active-low reset
//   g_clk_req  out  clock request, always 1 (pins are sampled continuously)
//   gpio       in   raw pin levels, asynchronous to g_clk
//   irq        out  registered interrupt, high while any PENDING bit is set
//   memif      RSP  register port: 0x00 STATUS, 0x04 RISE_EN, 0x08 FALL_EN,
//                   0x0C PENDING (W1C), 0x10 LEVEL_EN (optional)
// Optional feature macro: GPIO_IRQ_LEVEL_EN adds level-triggered pending via
//   LEVEL_EN at 0x10; without it 0x10 reads 0 and ignores writes.
module gpio_irq_ctrl #(
  parameter int          PERIPH_GPIO_NUM = 16,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] RESET_RISE_EN   = 32'h0,
  parameter logic [31:0] RESET_FALL_EN   = 32'h0
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  output logic                       g_clk_req,
  input  logic [PERIPH_GPIO_NUM-1:0] gpio,
  output logic                       irq,
  scarv_ccx_memif.RSP                memif
);

  localparam int NP = PERIPH_GPIO_NUM - 1;
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [4:0] A_STATUS  = 5'h00;
  localparam logic [4:0] A_RISE_EN = 5'h04;
  localparam logic [4:0] A_FALL_EN = 5'h08;
  localparam logic [4:0] A_PENDING = 5'h0C;
  localparam logic [4:0] A_LEVEL   = 5'h10;

  logic [NP:0]         sync1_q, sync2_q;
  logic [NP:0]         deb_q, deb_d;
  logic [NP:0]         deb_dly_q;
  logic [NP:0][CW-1:0] cnt_q, cnt_d;
  logic [NP:0]         rise_en_q, fall_en_q;
  logic [NP:0]         pending_q, pending_d;
  logic                irq_q;
  logic [NP:0]         rise, fall, edge_set, clr;
  logic                wr_en;
  logic [4:0]          offset;
  logic [31:0]         rd_data;
  logic                unused_bits;

  assign g_clk_req    = 1'b1;
  assign irq          = irq_q;
  assign memif.gnt    = 1'b1;
  assign memif.error  = 1'b0;
  assign memif.rdata  = rd_data;

  assign wr_en  = memif.req & memif.wen;
  assign offset = memif.addr[4:0];

  // Byte strobes and upper address bits play no part in decoding.
  assign unused_bits = ^{memif.strb, memif.addr[31:5], memif.wdata};

`ifdef GPIO_IRQ_LEVEL_EN
  logic [NP:0] level_en_q;
`endif

  // Debounce: the count restarts on any cycle of agreement, and the level
  // only flips once the disagreement has lasted DEBOUNCE_CYCLES+1 edges.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i <= NP; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise     = deb_q & ~deb_dly_q;
  assign fall     = ~deb_q & deb_dly_q;
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign clr      = (wr_en && offset == A_PENDING) ? memif.wdata[NP:0] : '0;

  // Edge sets win over a simultaneous clear. The level term is masked by the
  // clear so a W1C on a level-enabled bit drops it for exactly one cycle.
  always_comb begin
    pending_d = (pending_q & ~clr) | edge_set;
`ifdef GPIO_IRQ_LEVEL_EN
    pending_d = pending_d | (deb_q & level_en_q & ~clr);
`endif
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      A_STATUS:  rd_data = 32'(deb_q);
      A_RISE_EN: rd_data = 32'(rise_en_q);
      A_FALL_EN: rd_data = 32'(fall_en_q);
      A_PENDING: rd_data = 32'(pending_q);
`ifdef GPIO_IRQ_LEVEL_EN
      A_LEVEL:   rd_data = 32'(level_en_q);
`endif
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
      rise_en_q <= RESET_RISE_EN[NP:0];
      fall_en_q <= RESET_FALL_EN[NP:0];
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= gpio;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      irq_q     <= |pending_q;
      if (wr_en && offset == A_RISE_EN) rise_en_q <= memif.wdata[NP:0];
      if (wr_en && offset == A_FALL_EN) fall_en_q <= memif.wdata[NP:0];
    end
  end

`ifdef GPIO_IRQ_LEVEL_EN
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      level_en_q <= '0;
    end else if (wr_en && offset == A_LEVEL) begin
      level_en_q <= memif.wdata[NP:0];
    end
  end
`endif

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - scoreboard testbench for gpio_irq_ctrl
module tb_gpio_irq_ctrl;

  localparam int N = 16;

  localparam logic [4:0] A_STATUS  = 5'h00;
  localparam logic [4:0] A_RISE    = 5'h04;
  localparam logic [4:0] A_FALL    = 5'h08;
  localparam logic [4:0] A_PEND    = 5'h0C;
  localparam logic [4:0] A_LEVEL   = 5'h10;
  localparam logic [4:0] A_UNMAP   = 5'h14;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         clk_req;
  logic         irq;
  logic [N-1:0] gpio = '0;
  logic         irq_probe = 1'b0;

  scarv_ccx_memif mem ();

  gpio_irq_ctrl #(
    .PERIPH_GPIO_NUM(N),
    .DEBOUNCE_CYCLES(4),
    .RESET_RISE_EN  (32'h0),
    .RESET_FALL_EN  (32'h0)
  ) dut (
    .g_clk    (clk),
    .g_resetn (resetn),
    .g_clk_req(clk_req),
    .gpio     (gpio),
    .irq      (irq),
    .memif    (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read response
  // or an irq sample is requested, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (mem.req && !mem.wen) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got read response with empty scoreboard");
      end else begin
        e = rd_q.pop_front();
        check(e.name, mem.rdata, e.exp);
        check({e.name, "_handshake"}, {29'b0, clk_req, mem.gnt, mem.error}, 32'h6);
      end
    end
    if (irq_probe) begin
      if (irq_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL irq_unexpected: got irq probe with empty scoreboard");
      end else begin
        e = irq_q.pop_front();
        check(e.name, {31'b0, irq}, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input bit do_rd, input logic [4:0] a, input logic [31:0] exp,
                      input bit do_irq, input bit exp_irq, input string name);
    exp_t e;
    if (do_rd) begin
      mem.req  = 1'b1;
      mem.wen  = 1'b0;
      mem.addr = {27'b0, a};
      e.name = name;
      e.exp  = exp;
      rd_q.push_back(e);
    end
    if (do_irq) begin
      irq_probe = 1'b1;
      e.name = {name, "_irq"};
      e.exp  = {31'b0, exp_irq};
      irq_q.push_back(e);
    end
    tick(1);
    mem.req   = 1'b0;
    irq_probe = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    step(1'b1, a, exp, 1'b0, 1'b0, name);
  endtask

  task automatic rdi(input logic [4:0] a, input logic [31:0] exp, input bit exp_irq, input string name);
    step(1'b1, a, exp, 1'b1, exp_irq, name);
  endtask

  task automatic ci(input bit exp_irq, input string name);
    step(1'b0, 5'h0, 32'h0, 1'b1, exp_irq, name);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mem.req   = 1'b1;
    mem.wen   = 1'b1;
    mem.addr  = {27'b0, a};
    mem.wdata = d;
    tick(1);
    mem.req = 1'b0;
    mem.wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    mem.req   = 1'b0;
    mem.wen   = 1'b0;
    mem.strb  = 4'hF;
    mem.addr  = '0;
    mem.wdata = '0;
    resetn    = 1'b0;
    tick(3);
    resetn = 1'b1;

    // Reset state and unmapped offsets
    rdi(A_STATUS, 32'h0, 1'b0, "rst_status");
    rd(A_RISE, 32'h0, "rst_rise_en");
    rd(A_FALL, 32'h0, "rst_fall_en");
    rd(A_PEND, 32'h0, "rst_pending");
    rd(A_LEVEL, 32'h0, "rst_level");
    wr(A_UNMAP, 32'hFFFF_FFFF);
    rd(A_UNMAP, 32'h0, "unmapped");

    // Basic rising edge: pin changes just after edge 0
    wr(A_RISE, 32'h0001);
    rd(A_RISE, 32'h0001, "rise_en_rb");
    gpio[0] = 1'b1;
    tick(6);
    rdi(A_STATUS, 32'h0000, 1'b0, "rise_status_e6");
    rdi(A_STATUS, 32'h0001, 1'b0, "rise_status_e7");
    rdi(A_PEND, 32'h0001, 1'b0, "rise_pend_e8");
    rdi(A_PEND, 32'h0001, 1'b1, "rise_pend_e9");

    // Write-1-to-clear
    wr(A_RISE, 32'h0005);
    wr(A_FALL, 32'h0004);
    gpio[2] = 1'b1;
    tick(10);
    rdi(A_PEND, 32'h0005, 1'b1, "w1c_pre");
    wr(A_PEND, 32'h0004);
    rdi(A_PEND, 32'h0001, 1'b1, "w1c_bit2");
    wr(A_PEND, 32'h0001);
    rdi(A_PEND, 32'h0000, 1'b1, "w1c_bit0");
    ci(1'b0, "w1c_irq_drop");
    wr(A_PEND, 32'hFFFF);
    rd(A_PEND, 32'h0000, "w1c_not_pending");

    // Set versus clear: W1C lands on the same edge the falling edge sets bit 2
    gpio[2] = 1'b0;
    tick(7);
    wr(A_PEND, 32'h0004);
    rdi(A_PEND, 32'h0004, 1'b0, "collide_pend");
    ci(1'b1, "collide");
    wr(A_PEND, 32'h0004);
    tick(2);

    // Glitch rejection: 3 high, 1 low, 3 high, then a 4-cycle pulse
    wr(A_RISE, 32'hFFFF);
    wr(A_FALL, 32'hFFFF);
    gpio[3] = 1'b1;
    tick(3);
    gpio[3] = 1'b0;
    tick(1);
    gpio[3] = 1'b1;
    tick(3);
    gpio[3] = 1'b0;
    tick(10);
    gpio[3] = 1'b1;
    tick(4);
    gpio[3] = 1'b0;
    tick(12);
    rdi(A_STATUS, 32'h0001, 1'b0, "glitch_status");
    rd(A_PEND, 32'h0000, "glitch_pend");

    // A 5-cycle pulse is the shortest that passes the filter
    gpio[4] = 1'b1;
    tick(5);
    gpio[4] = 1'b0;
    tick(14);
    rdi(A_PEND, 32'h0010, 1'b1, "pulse5_pend");
    wr(A_PEND, 32'hFFFF);
    tick(1);

    // Reset in the middle of debounce
    gpio = 16'hFFFF;
    tick(3);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    rdi(A_STATUS, 32'h0, 1'b0, "rstmid_status");
    rd(A_PEND, 32'h0, "rstmid_pend");
    rd(A_RISE, 32'h0, "rstmid_rise_en");
    wr(A_RISE, 32'hFFFF);
    tick(2);
    rd(A_STATUS, 32'h0000, "rstmid_status_e6");
    rdi(A_STATUS, 32'hFFFF, 1'b0, "rstmid_status_e7");
    rdi(A_PEND, 32'hFFFF, 1'b0, "rstmid_pend_e8");
    ci(1'b1, "rstmid_e9");

    // Enable changes neither clear nor retroactively set pending bits
    wr(A_RISE, 32'h0);
    rdi(A_PEND, 32'hFFFF, 1'b1, "en_change_keeps");
    wr(A_PEND, 32'hFFFF);
    gpio = 16'h0000;
    tick(10);
    wr(A_FALL, 32'hFFFF);
    rdi(A_PEND, 32'h0, 1'b0, "no_retro");

`ifdef GPIO_IRQ_LEVEL_EN
    wr(A_LEVEL, 32'h0002);
    rd(A_LEVEL, 32'h0002, "lvl_rb");
    gpio[1] = 1'b1;
    tick(10);
    rd(A_PEND, 32'h0002, "lvl_pend");
    wr(A_PEND, 32'h0002);
    rd(A_PEND, 32'h0000, "lvl_clr");
    rd(A_PEND, 32'h0002, "lvl_reassert");
`else
    wr(A_LEVEL, 32'h0002);
    rd(A_LEVEL, 32'h0000, "lvl_absent");
`endif

    tick(2);
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d reads and %0d irq samples outstanding expected 0",
               rd_q.size(), irq_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
